// File: rtl/conv_pkg.sv
// Shared constants and FSM state type for the 5x5 convolution MAC datapath.
//   TAPS    : taps per window (5x5)
//   W_FRAC  : fractional bits of the fixed-point weight (Q1.W_FRAC)
//   WQ_W    : fixed-point weight width including sign
//   PIX_W   : unsigned pixel width
//   PROD_W  : signed pixel*weight product width
//   ACC_W   : signed accumulator / result width
package conv_pkg;

   localparam int TAPS   = 25;
   localparam int W_FRAC = 14;
   localparam int WQ_W   = W_FRAC + 3;
   localparam int PIX_W  = 8;
   localparam int PROD_W = PIX_W + WQ_W;
   localparam int ACC_W  = 32;
   localparam int IDX_W  = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/fp16_to_qfix.sv
// Combinational FP16 -> signed fixed-point weight converter.
//   fp16 : IEEE half-precision weight
//   qfix : signed Q1.W_FRAC weight (WQ_W bits); denormals flush to zero,
//          inf/NaN and out-of-range exponents saturate to +/-32767.
module fp16_to_qfix
   import conv_pkg::*;
(
   input  logic [15:0]            fp16,
   output logic signed [WQ_W-1:0] qfix
);

   logic       sgn;
   logic [4:0] expo;
   logic [15:0] mant_ext;
   logic [15:0] mag;

   assign sgn      = fp16[15];
   assign expo     = fp16[14:10];
   assign mant_ext = {5'd0, 1'b1, fp16[9:0]};

   // Exponent 15 is unity (bias 15); the implicit-one mantissa sits at 2^10,
   // so exponent 11 leaves the mantissa aligned to the 2^-14 output grid.
   always_comb begin
      mag = 16'd0;
      if (expo == 5'd0) begin
         mag = 16'd0;
      end else if (expo >= 5'd16) begin
         mag = 16'd32767;
      end else if (expo >= 5'd11) begin
         mag = mant_ext << (expo - 5'd11);
      end else begin
         mag = mant_ext >> (5'd11 - expo);
      end
   end

   always_comb begin
      if (sgn) begin
         qfix = -$signed({1'b0, mag});
      end else begin
         qfix = $signed({1'b0, mag});
      end
   end

endmodule

// File: rtl/conv5x5_mac_seq.sv
// 5x5 window multiply-accumulate sequencer.
// Walks the weight-table index over 0..TAPS-1, pairs each FP16 weight with one
// streamed pixel, converts the weight to fixed point and accumulates the
// products through a three-stage pipeline. One dot product per window is
// presented on a valid/ready output.
//   clk, rst_n           : clock, asynchronous active-low reset
//   start                : begin a window (honoured only in IDLE)
//   pix_valid/ready/data : pixel stream, row-major, accepted on valid & ready
//   tbl_indx, tbl_tv     : weight-table index out, FP16 weight back (combinational table)
//   out_valid/ready/data : signed dot product, scale 2^-W_FRAC
//   busy                 : window in progress (state != IDLE)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting pixels, one tap per accept
// DRAIN | last tap accepted, waiting for the pipeline to empty
// DONE  | result held on out_data until the consumer takes it
module conv5x5_mac_seq
   import conv_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    pix_valid,
   input  logic [PIX_W-1:0]        pix_data,
   output logic                    pix_ready,
   output logic [IDX_W-1:0]        tbl_indx,
   input  logic [15:0]             tbl_tv,
   output logic                    out_valid,
   output logic signed [ACC_W-1:0] out_data,
   input  logic                    out_ready,
   output logic                    busy
);

   state_e                  state;
   logic [IDX_W-1:0]        count;
   logic                    accept;
   logic                    last_tap;
   logic signed [WQ_W-1:0]  w_fix;

   logic                    s1_v;
   logic [PIX_W-1:0]        s1_pix;
   logic signed [WQ_W-1:0]  s1_w;
   logic                    s2_v;
   logic signed [PROD_W-1:0] s2_prod;
   logic signed [ACC_W-1:0] acc;

   logic signed [PROD_W-1:0] pix_ext;
   logic signed [PROD_W-1:0] w_ext;
   logic signed [PROD_W-1:0] product;

   fp16_to_qfix u_cvt (
      .fp16 (tbl_tv),
      .qfix (w_fix)
   );

   assign pix_ready = (state == RUN);
   assign accept    = pix_valid & pix_ready;
   assign last_tap  = accept && (count == IDX_W'(TAPS - 1));
   assign tbl_indx  = count;
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign out_data  = acc;

   // Both operands are widened to the product width; the true product always
   // fits in PROD_W bits so the truncating multiply is exact.
   assign pix_ext = $signed({{(PROD_W-PIX_W){1'b0}}, s1_pix});
   assign w_ext   = {{(PROD_W-WQ_W){s1_w[WQ_W-1]}}, s1_w};
   assign product = pix_ext * w_ext;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state <= RUN;
                  count <= '0;
               end
            end
            RUN: begin
               if (last_tap) begin
                  state <= DRAIN;
                  count <= '0;
               end else if (accept) begin
                  count <= count + IDX_W'(1);
               end
            end
            // S2 always retires on the edge after S1 empties, so the
            // pipeline is empty once S1 holds nothing.
            DRAIN: begin
               if (!s1_v) begin
                  state <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v    <= 1'b0;
         s1_pix  <= '0;
         s1_w    <= '0;
         s2_v    <= 1'b0;
         s2_prod <= '0;
         acc     <= '0;
      end else begin
         s1_v <= accept;
         if (accept) begin
            s1_pix <= pix_data;
            s1_w   <= w_fix;
         end
         s2_v <= s1_v;
         if (s1_v) begin
            s2_prod <= product;
         end
         if ((state == IDLE) && start) begin
            acc <= '0;
         end else if (s2_v) begin
            acc <= acc + {{(ACC_W-PROD_W){s2_prod[PROD_W-1]}}, s2_prod};
         end
      end
   end

endmodule
